// File: rtl/uart_frame_loader_if.sv
// Purpose: bundles the UART RX byte stream, the FFT sample-buffer write port,
//          the frame handshake and the status flags of uart_frame_loader.
// Ports (master = loader side):
//   i_rx_byte/i_rx_valid/i_rx_error : received byte, valid pulse, framing-error pulse
//   o_wr_en/o_wr_addr/o_wr_data     : sample write strobe, index 0..15, {MSB,LSB}
//   o_frame_valid/i_frame_ack       : checked frame ready / taken by FFT core
//   o_frame_err/o_err_code          : abort pulse and held cause (01 tmo, 10 uart, 11 csum)
//   o_overrun/o_busy                : sticky byte-while-waiting flag, LOAD/CHECK indicator
interface uart_frame_loader_if;
    logic [7:0]  i_rx_byte;
    logic        i_rx_valid;
    logic        i_rx_error;
    logic        o_wr_en;
    logic [3:0]  o_wr_addr;
    logic [15:0] o_wr_data;
    logic        o_frame_valid;
    logic        i_frame_ack;
    logic        o_frame_err;
    logic [1:0]  o_err_code;
    logic        o_overrun;
    logic        o_busy;

    modport master (
        input  i_rx_byte, i_rx_valid, i_rx_error, i_frame_ack,
        output o_wr_en, o_wr_addr, o_wr_data, o_frame_valid,
               o_frame_err, o_err_code, o_overrun, o_busy
    );

    modport slave (
        output i_rx_byte, i_rx_valid, i_rx_error, i_frame_ack,
        input  o_wr_en, o_wr_addr, o_wr_data, o_frame_valid,
               o_frame_err, o_err_code, o_overrun, o_busy
    );
endinterface

// File: rtl/uart_frame_loader.sv
// Purpose: hunts for the header byte, packs 32 payload bytes into 16 x 16-bit
//          FFT samples, validates the XOR checksum and offers the frame to the
//          FFT core; aborts on inter-byte timeout, UART error or bad checksum.
// Ports:
//   i_clk : system clock (rising edge)
//   i_rst : asynchronous active-high reset
//   bus   : uart_frame_loader_if.master (RX bytes, sample writes, handshake, status)
module uart_frame_loader #(
    parameter int unsigned SAMPLES      = 16,
    parameter logic [7:0]  HEADER       = 8'hA5,
    parameter int unsigned TIMEOUT_CLKS = 1600
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    uart_frame_loader_if.master  bus
);
    localparam int unsigned AW    = $clog2(SAMPLES);
    localparam int unsigned IDX_W = AW + 1;
    localparam int unsigned TW    = 16;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2 * SAMPLES - 1);
    localparam logic [TW-1:0]    TMO_MAX  = TW'(TIMEOUT_CLKS - 1);

    localparam logic [1:0] CODE_TMO  = 2'b01;
    localparam logic [1:0] CODE_UART = 2'b10;
    localparam logic [1:0] CODE_CSUM = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CHECK, S_READY} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       lsb_q, lsb_d;
    logic [7:0]       csum_q, csum_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic             wr_en_q, wr_en_d;
    logic [AW-1:0]    wr_addr_q, wr_addr_d;
    logic [15:0]      wr_data_q, wr_data_d;
    logic             fvalid_q, fvalid_d;
    logic             ferr_q, ferr_d;
    logic [1:0]       code_q, code_d;
    logic             ovr_q, ovr_d;
    logic             busy_q, busy_d;
    logic             abort_c;
    logic [1:0]       abort_code_c;

    // State and registered outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            lsb_q     <= '0;
            csum_q    <= '0;
            tmo_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            fvalid_q  <= 1'b0;
            ferr_q    <= 1'b0;
            code_q    <= '0;
            ovr_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            lsb_q     <= lsb_d;
            csum_q    <= csum_d;
            tmo_q     <= tmo_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            fvalid_q  <= fvalid_d;
            ferr_q    <= ferr_d;
            code_q    <= code_d;
            ovr_q     <= ovr_d;
            busy_q    <= busy_d;
        end
    end

    // Next state and next output values
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        lsb_d        = lsb_q;
        csum_d       = csum_q;
        tmo_d        = tmo_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        fvalid_d     = fvalid_q;
        ferr_d       = 1'b0;
        code_d       = code_q;
        ovr_d        = ovr_q;
        abort_c      = 1'b0;
        abort_code_c = CODE_TMO;

        unique case (state_q)
            S_IDLE: begin
                if (bus.i_rx_valid && bus.i_rx_byte == HEADER) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                    csum_d  = '0;
                    tmo_d   = '0;
                end
            end
            S_LOAD, S_CHECK: begin
                // A framing error outranks a coincident byte, which is then dropped
                if (bus.i_rx_error) begin
                    abort_c      = 1'b1;
                    abort_code_c = CODE_UART;
                end else if (bus.i_rx_valid) begin
                    tmo_d = '0;
                    if (state_q == S_LOAD) begin
                        csum_d = csum_q ^ bus.i_rx_byte;
                        if (!idx_q[0]) begin
                            lsb_d = bus.i_rx_byte;
                        end else begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = idx_q[IDX_W-1:1];
                            wr_data_d = {bus.i_rx_byte, lsb_q};
                        end
                        if (idx_q == LAST_IDX) begin
                            state_d = S_CHECK;
                        end else begin
                            idx_d = IDX_W'(idx_q + 1'b1);
                        end
                    end else if (bus.i_rx_byte == csum_q) begin
                        state_d  = S_READY;
                        fvalid_d = 1'b1;
                    end else begin
                        abort_c      = 1'b1;
                        abort_code_c = CODE_CSUM;
                    end
                end else if (tmo_q == TMO_MAX) begin
                    abort_c      = 1'b1;
                    abort_code_c = CODE_TMO;
                end else begin
                    tmo_d = TW'(tmo_q + 1'b1);
                end
            end
            S_READY: begin
                if (bus.i_frame_ack) begin
                    fvalid_d = 1'b0;
                    ovr_d    = 1'b0;
                    state_d  = S_IDLE;
                end else if (bus.i_rx_valid) begin
                    ovr_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (abort_c) begin
            state_d = S_IDLE;
            ferr_d  = 1'b1;
            code_d  = abort_code_c;
        end

        busy_d = (state_d == S_LOAD) || (state_d == S_CHECK);
    end

    assign bus.o_wr_en       = wr_en_q;
    assign bus.o_wr_addr     = wr_addr_q;
    assign bus.o_wr_data     = wr_data_q;
    assign bus.o_frame_valid = fvalid_q;
    assign bus.o_frame_err   = ferr_q;
    assign bus.o_err_code    = code_q;
    assign bus.o_overrun     = ovr_q;
    assign bus.o_busy        = busy_q;
endmodule

// File: tb/tb_uart_frame_loader.sv
// Purpose: self-checking bench for uart_frame_loader. Frame-level vectors come
//          from a table; sample writes are checked against a scoreboard queue.
module tb_uart_frame_loader;
    logic i_clk;
    logic i_rst;

    uart_frame_loader_if bus();

    uart_frame_loader dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [19:0] exp_q[$];
    logic [19:0] act_q[$];
    int          act_rd     = 0;
    int          err_pulses = 0;
    logic [1:0]  last_code  = 2'b00;

    // Collect DUT writes and error pulses away from the active edge
    always @(negedge i_clk) begin
        if (bus.o_wr_en)
            act_q.push_back({bus.o_wr_addr, bus.o_wr_data});
        if (bus.o_frame_err) begin
            err_pulses = err_pulses + 1;
            last_code  = bus.o_err_code;
        end
    end

    typedef struct {
        string      name;
        logic [7:0] csum_xor;
        int         err_at;
        logic       exp_valid;
        int         exp_errs;
        logic [1:0] exp_code;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pbyte(input int j);
        logic [7:0] k;
        k = 8'(j >> 1);
        return (j % 2 == 1) ? k : 8'(k + 8'd1);
    endfunction

    task automatic send(input logic [7:0] b, input logic err);
        @(negedge i_clk);
        bus.i_rx_byte  = b;
        bus.i_rx_valid = 1'b1;
        bus.i_rx_error = err;
        @(negedge i_clk);
        bus.i_rx_valid = 1'b0;
        bus.i_rx_error = 1'b0;
        repeat (2) @(negedge i_clk);
    endtask

    task automatic drain(input string name);
        logic [19:0] e;
        while (act_rd < act_q.size()) begin
            if (exp_q.size() == 0) begin
                chk({name, " unexpected write"}, 32'(act_q[act_rd]), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk({name, " write"}, 32'(act_q[act_rd]), 32'(e));
            end
            act_rd++;
        end
        chk({name, " missing writes"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic ack();
        @(negedge i_clk);
        bus.i_frame_ack = 1'b1;
        @(negedge i_clk);
        bus.i_frame_ack = 1'b0;
    endtask

    // Send header, payload up to err_at (error pulse there) and checksum
    task automatic send_frame(input logic [7:0] csum_xor, input int err_at);
        logic [7:0] cs;
        logic       stopped;
        cs      = 8'h00;
        stopped = 1'b0;
        send(8'hA5, 1'b0);
        for (int j = 0; j < 32; j++) begin
            if (!stopped) begin
                if (j == err_at) begin
                    send(pbyte(j), 1'b1);
                    stopped = 1'b1;
                end else begin
                    if (j % 2 == 1)
                        exp_q.push_back({4'(j >> 1), pbyte(j), pbyte(j - 1)});
                    cs = cs ^ pbyte(j);
                    send(pbyte(j), 1'b0);
                end
            end
        end
        if (!stopped)
            send(cs ^ csum_xor, 1'b0);
    endtask

    initial begin
        int e0;
        int waited;
        bit seen;

        vecs[0] = '{"good",      8'h00, -1, 1'b1, 0, 2'b00};
        vecs[1] = '{"bad_csum",  8'h01, -1, 1'b0, 1, 2'b11};
        vecs[2] = '{"uart_err",  8'h00,  5, 1'b0, 1, 2'b10};
        vecs[3] = '{"good_again",8'h00, -1, 1'b1, 0, 2'b00};

        i_rst           = 1'b1;
        bus.i_rx_byte   = 8'h00;
        bus.i_rx_valid  = 1'b0;
        bus.i_rx_error  = 1'b0;
        bus.i_frame_ack = 1'b0;
        repeat (3) @(negedge i_clk);
        chk("rst wr_en",  32'(bus.o_wr_en), 32'd0);
        chk("rst fvalid", 32'(bus.o_frame_valid), 32'd0);
        chk("rst code",   32'(bus.o_err_code), 32'd0);
        chk("rst busy",   32'(bus.o_busy), 32'd0);
        i_rst = 1'b0;
        repeat (2) @(negedge i_clk);

        for (int v = 0; v < 4; v++) begin
            e0 = err_pulses;
            send_frame(vecs[v].csum_xor, vecs[v].err_at);
            repeat (3) @(negedge i_clk);
            drain(vecs[v].name);
            chk({vecs[v].name, " fvalid"}, 32'(bus.o_frame_valid), 32'(vecs[v].exp_valid));
            chk({vecs[v].name, " err pulses"}, 32'(err_pulses - e0), 32'(vecs[v].exp_errs));
            chk({vecs[v].name, " busy"}, 32'(bus.o_busy), 32'd0);
            if (vecs[v].exp_errs != 0)
                chk({vecs[v].name, " code"}, 32'(last_code), 32'(vecs[v].exp_code));
            if (bus.o_frame_valid) begin
                ack();
                chk({vecs[v].name, " fvalid after ack"}, 32'(bus.o_frame_valid), 32'd0);
            end
        end

        // Overrun while waiting for ack
        send_frame(8'h00, -1);
        repeat (2) @(negedge i_clk);
        drain("ovr frame");
        chk("ovr fvalid", 32'(bus.o_frame_valid), 32'd1);
        chk("ovr before", 32'(bus.o_overrun), 32'd0);
        send(8'h11, 1'b0);
        send(8'hA5, 1'b0);
        send(8'h22, 1'b0);
        chk("ovr set",       32'(bus.o_overrun), 32'd1);
        chk("ovr fvalid hold", 32'(bus.o_frame_valid), 32'd1);
        ack();
        chk("ovr cleared",   32'(bus.o_overrun), 32'd0);
        chk("ovr fvalid clr", 32'(bus.o_frame_valid), 32'd0);
        send(8'hA5, 1'b0);
        chk("ovr idle->load", 32'(bus.o_busy), 32'd1);

        // Timeout: ten payload bytes after the header above, then silence
        for (int j = 0; j < 10; j++) begin
            if (j % 2 == 1)
                exp_q.push_back({4'(j >> 1), pbyte(j), pbyte(j - 1)});
            send(pbyte(j), 1'b0);
        end
        waited = 0;
        seen   = 1'b0;
        while (!seen && waited < 2000) begin
            @(negedge i_clk);
            waited++;
            if (bus.o_frame_err) seen = 1'b1;
        end
        chk("tmo seen", 32'(seen), 32'd1);
        chk("tmo window", 32'(waited >= 1596 && waited <= 1600), 32'd1);
        chk("tmo code", 32'(bus.o_err_code), 32'd1);
        repeat (2) @(negedge i_clk);
        chk("tmo busy", 32'(bus.o_busy), 32'd0);
        drain("tmo");
        send_frame(8'h00, -1);
        repeat (2) @(negedge i_clk);
        drain("post tmo");
        chk("post tmo fvalid", 32'(bus.o_frame_valid), 32'd1);
        ack();

        // Non-header bytes in IDLE, then reset in the middle of LOAD
        e0 = err_pulses;
        send(8'h00, 1'b0);
        send(8'hFF, 1'b0);
        chk("idle drop busy", 32'(bus.o_busy), 32'd0);
        send(8'hA5, 1'b0);
        chk("hdr busy", 32'(bus.o_busy), 32'd1);
        for (int j = 0; j < 4; j++) begin
            if (j % 2 == 1)
                exp_q.push_back({4'(j >> 1), pbyte(j), pbyte(j - 1)});
            send(pbyte(j), 1'b0);
        end
        drain("pre rst");
        @(negedge i_clk);
        #2 i_rst = 1'b1;
        #1;
        chk("mid rst busy",  32'(bus.o_busy), 32'd0);
        chk("mid rst data",  32'(bus.o_wr_data), 32'd0);
        chk("mid rst addr",  32'(bus.o_wr_addr), 32'd0);
        chk("mid rst code",  32'(bus.o_err_code), 32'd0);
        chk("mid rst ovr",   32'(bus.o_overrun), 32'd0);
        chk("mid rst err",   32'(bus.o_frame_err), 32'd0);
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        repeat (4) @(negedge i_clk);
        chk("rst no err pulse", 32'(err_pulses - e0), 32'd0);
        chk("rst idle busy", 32'(bus.o_busy), 32'd0);
        drain("post rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
